rf_write_buffer: RTL
====================

Name: rf_write_buffer

Overview:
- Writer-side companion to the register file write/read port bundle (wr_en, wr_reg, wr_data, rd_reg_1/2, rd_data_1/2).
- Accepts late-arriving writeback requests (e.g. multi-cycle unit results) through a valid/ready handshake and queues them in a small FIFO.
- Drains the queue into the register file write port whenever the pipeline is not using that port.
- Forwards queued-but-unwritten values onto the read path, so readers never see stale register data.

Parameters:
- DEPTH, 4, number of queued write entries; power of two, at least 2.
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register index width (32 registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  write request valid.
- in_ready  output  1  buffer can accept the request this cycle.
- in_reg  input  ADDR_WIDTH  destination register.
- in_data  input  DATA_WIDTH  data to write.
- port_busy  input  1  pipeline owns the register file write port this cycle.
- rf_wr_en  output  1  drives the register file wr_en.
- rf_wr_reg  output  ADDR_WIDTH  drives the register file wr_reg.
- rf_wr_data  output  DATA_WIDTH  drives the register file wr_data.
- rd_reg_1  input  ADDR_WIDTH  read index 1; the same value goes to the register file.
- rd_reg_2  input  ADDR_WIDTH  read index 2.
- rf_rd_data_1  input  DATA_WIDTH  raw register file rd_data_1.
- rf_rd_data_2  input  DATA_WIDTH  raw register file rd_data_2.
- rd_data_1  output  DATA_WIDTH  forwarded read data 1.
- rd_data_2  output  DATA_WIDTH  forwarded read data 2.
- count  output  $clog2(DEPTH+1)  number of occupied entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Reset (async assert, sync release): head, tail and count go to 0; all entry valid bits clear. Outputs are then empty=1, full=0, in_ready=1, rf_wr_en=0, rf_wr_reg=0, rf_wr_data=0, count=0. Reset mid-drain discards all pending entries; none are written.
- Storage: circular FIFO of {reg, data}, indexed by head and tail pointers that wrap modulo DEPTH.
- Push: push = in_valid && in_ready && (in_reg != 0). Entry is written at tail and tail increments.
- Writes to x0: in_valid with in_reg == 0 is handshaken (in_ready governs as usual) but dropped; count does not change.
- in_ready = !full || pop. Push into a full buffer is allowed only in the same cycle as a pop.
- Drain: rf_wr_en = !empty && !port_busy. rf_wr_reg and rf_wr_data show the head entry combinationally, and are 0 when empty.
- Pop: pop = rf_wr_en. Head increments at the clock edge; the register file captures the data on that same edge.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Latency: a request pushed in cycle N is at the head in cycle N+1 if the buffer was empty. Earliest register file write is the N+1 edge.
- Ordering: strict FIFO order. Multiple pending writes to the same register are all committed in order.
- Forwarding, per read port n:
  - If rd_reg_n == 0, rd_data_n = 0.
  - Else, if any valid entry (head included, even while it is being popped) matches rd_reg_n, rd_data_n = data of the youngest matching entry (closest to tail).
  - Else rd_data_n = rf_rd_data_n.
- Forwarding is purely combinational.
- Same-cycle rule: an entry being pushed this cycle is NOT forwarded. It becomes visible the next cycle.
- The pipeline's own writes while port_busy is high are not tracked. The hazard unit must stall issue of the same register while it is queued; this block does not check for it.

Decomposition:
- Package rf_pkg:
  - REG_ADDR_WIDTH = 5, REG_DATA_WIDTH = 32, NUM_REGS = 32.
  - typedef rf_addr_t, rf_data_t.
  - struct rf_wr_entry_t {reg, data}, shared with the monitor and scoreboard.
- One natural sub-module: rf_fwd_match. It holds one read port's youngest-match priority search over the entry array and is instantiated twice.

Test Plan:
- Basic write: reset, port_busy=0. Push (reg 5, 0xDEADBEEF). Next cycle: rf_wr_en=1, rf_wr_reg=5, rf_wr_data=0xDEADBEEF, count=1. Following cycle: count=0, empty=1.
- Fill and backpressure: port_busy=1, push regs 1..4 with data 0x11..0x44. Then full=1 and in_ready=0; a 5th request stalls. Drop port_busy: writes appear on consecutive cycles in order 1,2,3,4; the 5th request is accepted on the first pop cycle.
- Forwarding: port_busy=1, push (reg 7, 0xA) then (reg 7, 0xB), with rf_rd_data_1=0x0 and rd_reg_1=7 → rd_data_1=0xB. Release port_busy: after both pops, rd_data_1 follows rf_rd_data_1.
- x0 handling: push (reg 0, 0xFFFF) → in_ready=1, count stays 0, rf_wr_en stays 0. rd_reg_2=0 with rf_rd_data_2=0x5 → rd_data_2=0.
- Simultaneous push/pop at full: DEPTH entries queued, port_busy=0, in_valid=1 → pop and push in the same cycle, count stays DEPTH, tail wraps past index DEPTH−1 to 0, order preserved.
- Reset mid-operation: 3 entries queued with port_busy=1, assert rst asynchronously between edges → count=0, rf_wr_en=0 immediately. After release none of the 3 registers are written.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file types for the write buffer, its forwarding search and the bench.
package rf_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int NUM_REGS       = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [REG_DATA_WIDTH-1:0] rf_data_t;

    // 'reg' is a keyword, so the destination field is called addr.
    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } rf_wr_entry_t;

endpackage

// File: rtl/rf_fwd_match.sv
// Youngest-match search of the queued writes for one read port, falling back to the
// raw register file value; x0 always reads as zero.
module rf_fwd_match
    import rf_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]      entry_valid,
    input  logic [ADDR_WIDTH-1:0] entry_reg  [DEPTH],
    input  logic [DATA_WIDTH-1:0] entry_data [DEPTH],
    input  logic [PTR_W-1:0]      head,
    input  logic [ADDR_WIDTH-1:0] rd_reg,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic                  hit;
    logic [DATA_WIDTH-1:0] hit_data;
    logic [PTR_W-1:0]      idx;

    // Walk oldest (head) to youngest; a later match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (entry_valid[idx] && (entry_reg[idx] == rd_reg)) begin
                hit      = 1'b1;
                hit_data = entry_data[idx];
            end
        end
    end

    always_comb begin
        if (rd_reg == '0)
            rd_data = '0;
        else if (hit)
            rd_data = hit_data;
        else
            rd_data = rf_rd_data;
    end

endmodule

// File: rtl/rf_write_buffer.sv
// Queues late writeback requests and drains them into the register file write port
// whenever the pipeline leaves it idle, forwarding queued data onto both read ports.
module rf_write_buffer
    import rf_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_reg,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       port_busy,
    output logic                       rf_wr_en,
    output logic [ADDR_WIDTH-1:0]      rf_wr_reg,
    output logic [DATA_WIDTH-1:0]      rf_wr_data,
    input  logic [ADDR_WIDTH-1:0]      rd_reg_1,
    input  logic [ADDR_WIDTH-1:0]      rd_reg_2,
    input  logic [DATA_WIDTH-1:0]      rf_rd_data_1,
    input  logic [DATA_WIDTH-1:0]      rf_rd_data_2,
    output logic [DATA_WIDTH-1:0]      rd_data_1,
    output logic [DATA_WIDTH-1:0]      rd_data_2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] ent_reg  [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]      ent_valid;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count_q;
    logic                  push;
    logic                  pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign rf_wr_en = !empty && !port_busy;
    assign pop      = rf_wr_en;
    assign in_ready = !full || pop;
    // x0 requests complete the handshake but never occupy an entry.
    assign push     = in_valid && in_ready && (in_reg != '0);

    assign rf_wr_reg  = empty ? '0 : ent_reg[head];
    assign rf_wr_data = empty ? '0 : ent_data[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
            ent_valid <= '0;
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            // At full with a pop, tail equals head: the set must win over the clear.
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_reg[tail]  <= in_reg;
            ent_data[tail] <= in_data;
        end
    end

    rf_fwd_match #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PTR_W      (PTR_W)
    ) u_fwd_1 (
        .entry_valid (ent_valid),
        .entry_reg   (ent_reg),
        .entry_data  (ent_data),
        .head        (head),
        .rd_reg      (rd_reg_1),
        .rf_rd_data  (rf_rd_data_1),
        .rd_data     (rd_data_1)
    );

    rf_fwd_match #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PTR_W      (PTR_W)
    ) u_fwd_2 (
        .entry_valid (ent_valid),
        .entry_reg   (ent_reg),
        .entry_data  (ent_data),
        .head        (head),
        .rd_reg      (rd_reg_2),
        .rf_rd_data  (rf_rd_data_2),
        .rd_data     (rd_data_2)
    );

endmodule
